// File: rtl/cla_4bit_adder.sv
// rtl/cla_4bit_adder.sv - registered 4-bit carry-lookahead adder
//
// Purpose:
//   Adds A + B + Cin using flat two-level generate/propagate lookahead.
//   Every carry is built from g/p/Cin directly, never from a computed carry.
//   Results are registered one cycle after an in_valid sample.
//
// Optional feature:
//   CLA_4BIT_GROUP_PG_EN - adds registered group propagate (GP) and group
//   generate (GG) outputs for cascading into a second-level lookahead unit.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  operands valid this cycle
//   A          in   4  operand A (unsigned or two's complement)
//   B          in   4  operand B
//   Cin        in   1  carry input
//   Sum        out  4  registered sum
//   Cout       out  1  registered carry out of bit 3
//   Ovf        out  1  registered signed overflow (c4 ^ c3)
//   out_valid  out  1  registered; Sum/Cout/Ovf hold a new result
//   GP         out  1  registered group propagate (CLA_4BIT_GROUP_PG_EN only)
//   GG         out  1  registered group generate  (CLA_4BIT_GROUP_PG_EN only)

module cla_4bit_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       Ovf,
`ifdef CLA_4BIT_GROUP_PG_EN
  output logic       GP,
  output logic       GG,
`endif
  output logic       out_valid
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c0, c1, c2, c3, c4;

  logic [3:0] sum_d, sum_q;
  logic       cout_d, cout_q;
  logic       ovf_d, ovf_q;
  logic       valid_q;

  assign g  = A & B;
  assign p  = A ^ B;
  assign c0 = Cin;

  // Each carry is a single AND-OR plane over g, p and c0 so that no carry
  // depends on another computed carry.
  assign c1 = g[0]
            | (p[0] & c0);
  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & c0);
  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c0);
  assign c4 = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);

  assign sum_d  = p ^ {c3, c2, c1, c0};
  assign cout_d = c4;
  assign ovf_d  = c4 ^ c3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 4'b0000;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign out_valid = valid_q;

`ifdef CLA_4BIT_GROUP_PG_EN
  logic gp_d, gp_q;
  logic gg_d, gg_q;

  assign gp_d = p[3] & p[2] & p[1] & p[0];
  // Group generate is c4 with the carry-in term dropped (c0 = 0).
  assign gg_d = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      gp_q <= 1'b0;
      gg_q <= 1'b0;
    end else if (in_valid) begin
      gp_q <= gp_d;
      gg_q <= gg_d;
    end
  end

  assign GP = gp_q;
  assign GG = gg_q;
`endif

endmodule

// File: tb/tb_cla_4bit_adder.sv
// tb/tb_cla_4bit_adder.sv - directed and exhaustive bench for cla_4bit_adder

module tb_cla_4bit_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic       Ovf;
  logic       out_valid;
`ifdef CLA_4BIT_GROUP_PG_EN
  logic       GP;
  logic       GG;
`endif

  int n_vec = 0;
  int n_bad = 0;

  cla_4bit_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
`ifdef CLA_4BIT_GROUP_PG_EN
    .GP        (GP),
    .GG        (GG),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic step(input logic r, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic ci);
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] s, input logic co,
                            input logic ov, input logic vld);
    check({tag, ".sum"},   {4'b0, Sum},       {4'b0, s});
    check({tag, ".cout"},  {7'b0, Cout},      {7'b0, co});
    check({tag, ".ovf"},   {7'b0, Ovf},       {7'b0, ov});
    check({tag, ".valid"}, {7'b0, out_valid}, {7'b0, vld});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = 4'h0; B = 4'h0; Cin = 1'b0;

    // Reset for two cycles with valid operands present: reset must win.
    step(1'b1, 1'b1, 4'h7, 4'h7, 1'b1);
    step(1'b1, 1'b1, 4'h7, 4'h7, 1'b1);
    expect_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef CLA_4BIT_GROUP_PG_EN
    check("reset.gp", {7'b0, GP}, 8'h00);
    check("reset.gg", {7'b0, GG}, 8'h00);
`endif
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    expect_out("post_reset", 4'h0, 1'b0, 1'b0, 1'b0);

    // Basic sums.
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    expect_out("0+0", 4'b0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0);
    expect_out("3+1", 4'b0100, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0);
    expect_out("5+3", 4'b1000, 1'b0, 1'b1, 1'b1);

    // Carry-out wrap cases.
    step(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);
    expect_out("f+1", 4'b0000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_4BIT_GROUP_PG_EN
    check("f+1.gp", {7'b0, GP}, 8'h00);
    check("f+1.gg", {7'b0, GG}, 8'h01);
`endif
    step(1'b0, 1'b1, 4'b1001, 4'b0110, 1'b1);
    expect_out("9+6+1", 4'b0000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_4BIT_GROUP_PG_EN
    check("9+6+1.gp", {7'b0, GP}, 8'h01);
    check("9+6+1.gg", {7'b0, GG}, 8'h00);
`endif
    step(1'b0, 1'b1, 4'b1110, 4'b0001, 1'b1);
    expect_out("e+1+1", 4'b0000, 1'b1, 1'b0, 1'b1);

    // Hold: results stay put while in_valid is low.
    step(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0);
    expect_out("hold_load", 4'b0100, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'b1111, 4'b0001, 1'b0);
    expect_out("hold", 4'b0100, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1);
    expect_out("hold2", 4'b0100, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream: operands sampled with rst are discarded.
    step(1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0);
    expect_out("pre_rst", 4'b1000, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
    expect_out("mid_rst", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    expect_out("mid_rst_after", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0);
    expect_out("first_after_rst", 4'b0100, 1'b0, 1'b0, 1'b1);

    // Exhaustive back-to-back sweep against an arithmetic model.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      logic [3:0] a, b;
      logic       ci;
      logic [4:0] tot;
      logic       ov;
      iv  = i[8:0];
      a   = iv[3:0];
      b   = iv[7:4];
      ci  = iv[8];
      tot = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      // Signed overflow: operands share a sign that the result does not.
      ov  = (a[3] == b[3]) && (tot[3] != a[3]);
      step(1'b0, 1'b1, a, b, ci);
      check("exh.total", {3'b0, Cout, Sum}, {3'b0, tot});
      check("exh.ovf",   {7'b0, Ovf},       {7'b0, ov});
      check("exh.valid", {7'b0, out_valid}, 8'h01);
`ifdef CLA_4BIT_GROUP_PG_EN
      begin
        logic [4:0] tg;
        tg = {1'b0, a} + {1'b0, b};
        check("exh.gp", {7'b0, GP}, {7'b0, (a ^ b) == 4'hf});
        check("exh.gg", {7'b0, GG}, {7'b0, tg[4]});
      end
`endif
    end

    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    check("tail.valid", {7'b0, out_valid}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
